// File: rtl/sf_camera_clk_div_if.sv
// Control and status bundle of the multi-channel camera clock divider.
// The bench drives through master; the divider attaches as slave.
interface sf_camera_clk_div_if #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DIV_WIDTH = 8
);
  logic                        pll_locked;
  logic [NUM_CH-1:0]           ch_enable;
  logic [NUM_CH*DIV_WIDTH-1:0] div_value;
  logic [NUM_CH-1:0]           div_update;
  logic                        ready;
  logic [NUM_CH-1:0]           clk_out;
  logic [NUM_CH-1:0]           rise_stb;
  logic [NUM_CH-1:0]           fall_stb;
  logic [NUM_CH-1:0]           update_pending;

  modport master (
    output pll_locked, ch_enable, div_value, div_update,
    input  ready, clk_out, rise_stb, fall_stb, update_pending
  );

  modport slave (
    input  pll_locked, ch_enable, div_value, div_update,
    output ready, clk_out, rise_stb, fall_stb, update_pending
  );
endinterface

// File: rtl/sf_camera_clk_div.sv
// Lock-qualified, multi-channel programmable clock divider producing registered
// clock levels plus per-edge strobes; stops are glitch-free at period ends.
module sf_camera_clk_div #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned LOCK_WAIT   = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sf_camera_clk_div_if.slave    bus
);
  localparam int unsigned CNT_W   = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam int unsigned DEF_EFF = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
  localparam logic [DIV_WIDTH-1:0] DEF_N = DIV_WIDTH'(DEF_EFF);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} lock_state_t;

  lock_state_t      state;
  logic             lk_meta, lk, ready_r, run_ok;
  logic [CNT_W-1:0] stab_cnt;
  logic [NUM_CH-1:0] clk_q, rise_q, fall_q, pend_q;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
    return (v < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : v;
  endfunction

  // Lock synchroniser and lock FSM; the sample that leaves WAIT_LOCK counts
  // towards LOCK_WAIT, so RUN follows the LOCK_WAIT-th consecutive lk sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_meta  <= 1'b0;
      lk       <= 1'b0;
      state    <= WAIT_LOCK;
      stab_cnt <= '0;
      ready_r  <= 1'b0;
    end else begin
      lk_meta <= bus.pll_locked;
      lk      <= lk_meta;
      case (state)
        WAIT_LOCK: begin
          if (lk) begin
            stab_cnt <= '0;
            if (LOCK_WAIT <= 1) begin
              state   <= RUN;
              ready_r <= 1'b1;
            end else begin
              state <= STABLE;
            end
          end
        end
        STABLE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
          end else if (32'(stab_cnt) + 32'd2 >= LOCK_WAIT) begin
            state   <= RUN;
            ready_r <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            state   <= WAIT_LOCK;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Channels may only advance while RUN is held and lock is still present.
  assign run_ok = (state == RUN) && lk;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] cur_n, pend_n, pos, n_use, half, pos_inc, din;
    logic                 running, pend_f, at_end, apply, en;
    logic                 clk_r, rise_r, fall_r;

    // pos indexes the cycle currently presented; pending is only taken at a
    // period start or while idle, so the active phase lengths never change mid-period.
    always_comb begin
      en      = bus.ch_enable[i];
      din     = bus.div_value[i*DIV_WIDTH +: DIV_WIDTH];
      at_end  = running && (pos == cur_n - DIV_WIDTH'(1));
      apply   = pend_f && (!running || (at_end && en && run_ok));
      n_use   = apply ? pend_n : cur_n;
      half    = (cur_n >> 1) + DIV_WIDTH'(cur_n[0]);
      pos_inc = pos + DIV_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cur_n   <= DEF_N;
        pend_n  <= DEF_N;
        pend_f  <= 1'b0;
        running <= 1'b0;
        pos     <= '0;
        clk_r   <= 1'b0;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else begin
        cur_n <= n_use;
        if (bus.div_update[i]) begin
          pend_n <= clamp_div(din);
          pend_f <= 1'b1;
        end else if (apply) begin
          pend_f <= 1'b0;
        end

        if (!run_ok) begin
          running <= 1'b0;
          pos     <= '0;
          clk_r   <= 1'b0;
          rise_r  <= 1'b0;
          fall_r  <= 1'b0;
        end else if (!running || at_end) begin
          running <= en;
          pos     <= '0;
          clk_r   <= en;
          rise_r  <= en;
          fall_r  <= 1'b0;
        end else begin
          pos    <= pos_inc;
          clk_r  <= (pos_inc < half);
          rise_r <= 1'b0;
          fall_r <= (pos_inc == half);
        end
      end
    end

    assign clk_q[i]  = clk_r;
    assign rise_q[i] = rise_r;
    assign fall_q[i] = fall_r;
    assign pend_q[i] = pend_f;
  end

  assign bus.ready          = ready_r;
  assign bus.clk_out        = clk_q;
  assign bus.rise_stb       = rise_q;
  assign bus.fall_stb       = fall_q;
  assign bus.update_pending = pend_q;
endmodule

// File: tb/tb_sf_camera_clk_div.sv
// Self-checking bench for sf_camera_clk_div: directed scenarios with literal
// expectations plus a randomized phase compared every cycle to a period-level model.
module tb_sf_camera_clk_div;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DW     = 8;
  localparam int unsigned LW     = 16;
  localparam int unsigned DEF    = 4;

  logic clk = 1'b0;
  logic rst;
  bit   check_on = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  sf_camera_clk_div_if #(.NUM_CH(NUM_CH), .DIV_WIDTH(DW)) bus();

  sf_camera_clk_div #(
    .NUM_CH(NUM_CH), .DIV_WIDTH(DW), .LOCK_WAIT(LW), .DEFAULT_DIV(DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model state: lock streak history, and per channel run flag, cycle within
  // period, active N, pending flag and pending N.
  int h0, h1;
  bit m_ready;
  bit m_run  [NUM_CH];
  int m_t    [NUM_CH];
  int m_n    [NUM_CH];
  bit m_pend [NUM_CH];
  int m_pv   [NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready after edge k requires the LW lk samples ending at k all high, i.e. a
  // pll_locked streak of LW ending two edges earlier; channels need one more.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      h0 = 0; h1 = 0; m_ready = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i] = 1'b0; m_t[i] = 0; m_n[i] = DEF; m_pend[i] = 1'b0; m_pv[i] = DEF;
      end
    end else begin
      bit ok;
      ok = (h1 >= int'(LW) + 1);
      for (int i = 0; i < NUM_CH; i++) begin
        bit en, idle, bnd, app;
        int v;
        en   = bus.ch_enable[i];
        idle = !m_run[i];
        bnd  = m_run[i] && (m_t[i] == m_n[i] - 1);
        app  = m_pend[i] && (idle || (bnd && en && ok));
        if (!ok) begin
          m_run[i] = 1'b0; m_t[i] = 0;
        end else if (idle || bnd) begin
          m_run[i] = en; m_t[i] = 0;
        end else begin
          m_t[i] = m_t[i] + 1;
        end
        if (app) m_n[i] = m_pv[i];
        if (bus.div_update[i]) begin
          v = int'(bus.div_value[i*DW +: DW]);
          m_pv[i] = (v < 2) ? 2 : v;
          m_pend[i] = 1'b1;
        end else if (app) begin
          m_pend[i] = 1'b0;
        end
      end
      m_ready = (h1 >= int'(LW));
      h1 = h0;
      h0 = bus.pll_locked ? ((h0 < 100000) ? h0 + 1 : h0) : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (check_on) begin
      logic [NUM_CH-1:0] ec, er, ef, ep;
      for (int i = 0; i < NUM_CH; i++) begin
        int h;
        h = (m_n[i] + 1) / 2;
        ec[i] = m_run[i] && (m_t[i] < h);
        er[i] = m_run[i] && (m_t[i] == 0);
        ef[i] = m_run[i] && (m_t[i] == h);
        ep[i] = m_pend[i];
      end
      check("ready",          32'(bus.ready),          32'(m_ready));
      check("clk_out",        32'(bus.clk_out),        32'(ec));
      check("rise_stb",       32'(bus.rise_stb),       32'(er));
      check("fall_stb",       32'(bus.fall_stb),       32'(ef));
      check("update_pending", 32'(bus.update_pending), 32'(ep));
    end
  end

  task automatic drive_div(input int ch, input int v);
    bus.div_value[ch*DW +: DW] = DW'(v);
    bus.div_update[ch] = 1'b1;
    @(negedge clk);
    bus.div_update[ch] = 1'b0;
  endtask

  task automatic wait_rise(input int ch);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (bus.rise_stb[ch]) seen = 1'b1;
    end
    check("wait_rise_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [7:0] t2_clk, t2_pend;
    int hi, lo, rs, fs;
    rst = 1'b1;
    bus.pll_locked = 1'b1;
    bus.ch_enable  = 2'b01;
    bus.div_value  = '0;
    bus.div_update = '0;
    repeat (2) @(negedge clk);
    check_on = 1'b1;
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_clk",   32'(bus.clk_out), 32'd0);
    check("reset_pend",  32'(bus.update_pending), 32'd0);

    // Scenario 1: lock qualification and default divide on channel 0.
    @(negedge clk); rst = 1'b0;
    repeat (17) @(negedge clk);
    check("t1_ready_e17", 32'(bus.ready), 32'd0);
    @(negedge clk); check("t1_ready_e18", 32'(bus.ready), 32'd1);
    @(negedge clk); check("t1_clk_e19", 32'(bus.clk_out), 32'd1);
    check("t1_rise_e19", 32'(bus.rise_stb), 32'd1);
    @(negedge clk); check("t1_clk_e20", 32'(bus.clk_out), 32'd1);
    @(negedge clk); check("t1_clk_e21", 32'(bus.clk_out), 32'd0);
    check("t1_fall_e21", 32'(bus.fall_stb), 32'd1);
    @(negedge clk); check("t1_clk_e22", 32'(bus.clk_out), 32'd0);
    @(negedge clk); check("t1_clk_e23", 32'(bus.clk_out), 32'd1);

    // Scenario 2: N=5 running, reprogram to 3 one cycle into the high phase.
    drive_div(0, 5);
    wait_rise(0);
    bus.div_value[0 +: DW] = DW'(3);
    bus.div_update[0] = 1'b1;
    t2_clk  = 8'b1011_0011;
    t2_pend = 8'b0000_1111;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      bus.div_update[0] = 1'b0;
      check("t2_clk",  32'(bus.clk_out[0]),        32'(t2_clk[j-1]));
      check("t2_pend", 32'(bus.update_pending[0]), 32'(t2_pend[j-1]));
    end

    // Scenario 3: clamped divides 0 and 1, then 255, on idle channel 1.
    for (int v = 0; v < 2; v++) begin
      drive_div(1, v);
      bus.ch_enable[1] = 1'b1;
      wait_rise(1);
      check("t3_n2_hi", 32'(bus.clk_out[1]), 32'd1);
      @(negedge clk); check("t3_n2_lo",   32'(bus.clk_out[1]),  32'd0);
      check("t3_n2_fall", 32'(bus.fall_stb[1]), 32'd1);
      @(negedge clk); check("t3_n2_rise", 32'(bus.rise_stb[1]), 32'd1);
      bus.ch_enable[1] = 1'b0;
      repeat (4) @(negedge clk);
    end
    drive_div(1, 255);
    bus.ch_enable[1] = 1'b1;
    wait_rise(1);
    hi = 0; lo = 0; rs = 0; fs = 0;
    for (int k = 0; k < 400 && bus.clk_out[1]; k++) begin
      hi++; rs += int'(bus.rise_stb[1]); fs += int'(bus.fall_stb[1]);
      @(negedge clk);
    end
    for (int k = 0; k < 400 && !bus.clk_out[1]; k++) begin
      lo++; rs += int'(bus.rise_stb[1]); fs += int'(bus.fall_stb[1]);
      @(negedge clk);
    end
    check("t3_n255_high", 32'(hi), 32'd128);
    check("t3_n255_low",  32'(lo), 32'd127);
    check("t3_n255_rise", 32'(rs), 32'd1);
    check("t3_n255_fall", 32'(fs), 32'd1);
    bus.ch_enable[1] = 1'b0;
    repeat (300) @(negedge clk);

    // Scenario 4: N=8, disable one cycle into the high phase.
    drive_div(1, 8);
    bus.ch_enable[1] = 1'b1;
    wait_rise(1);
    bus.ch_enable[1] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check("t4_clk",  32'(bus.clk_out[1]),  (j <= 3) ? 32'd1 : 32'd0);
      check("t4_rise", 32'(bus.rise_stb[1]), 32'd0);
    end

    // Scenario 5: one-cycle lock drop during RUN, then re-qualification.
    bus.ch_enable = 2'b11;
    repeat (20) @(negedge clk);
    bus.pll_locked = 1'b0;
    @(negedge clk); bus.pll_locked = 1'b1;
    check("t5_ready_a", 32'(bus.ready), 32'd1);
    @(negedge clk); check("t5_ready_a1", 32'(bus.ready), 32'd1);
    @(negedge clk); check("t5_ready_a2", 32'(bus.ready), 32'd0);
    check("t5_clk_a2", 32'(bus.clk_out), 32'd0);
    repeat (15) @(negedge clk);
    check("t5_ready_a17", 32'(bus.ready), 32'd0);
    @(negedge clk); check("t5_ready_a18", 32'(bus.ready), 32'd1);
    repeat (30) @(negedge clk);

    // Randomized enables, reprogramming and lock dropouts.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      bus.div_update = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 19) == 0) bus.ch_enable[c] = ~bus.ch_enable[c];
        if ($urandom_range(0, 24) == 0) begin
          bus.div_value[c*DW +: DW] = DW'($urandom_range(0, 12));
          bus.div_update[c] = 1'b1;
        end
      end
      if (bus.pll_locked && $urandom_range(0, 299) == 0) bus.pll_locked = 1'b0;
      else if (!bus.pll_locked && $urandom_range(0, 2) == 0) bus.pll_locked = 1'b1;
    end
    bus.div_update = '0;
    bus.pll_locked = 1'b1;
    bus.ch_enable  = 2'b11;
    drive_div(1, 9);
    repeat (40) @(negedge clk);

    // Scenario 6: asynchronous reset in the middle of a high phase.
    wait_rise(0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_clk",   32'(bus.clk_out),        32'd0);
    check("t6_async_rise",  32'(bus.rise_stb),       32'd0);
    check("t6_async_ready", 32'(bus.ready),          32'd0);
    check("t6_async_pend",  32'(bus.update_pending), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (19) @(negedge clk);
    check("t6_restart_rise", 32'(bus.rise_stb), 32'd3);
    repeat (2) @(negedge clk);
    check("t6_default_fall", 32'(bus.fall_stb), 32'd3);
    repeat (20) @(negedge clk);

    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
